// File: rtl/lcd_bus_responder.sv
// HD44780-style LCD bus responder: decodes controller strobes into command/char pulses with busy timing.
// Read-back of {busy, AC} is compiled only when LCD_BUS_RESPONDER_READ_EN is defined.
module lcd_bus_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] LCD_DB,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_E,
  output logic [7:0] LCD_DB_rd,
  output logic       LCD_DB_oe,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       char_valid,
  output logic [7:0] char_data,
  output logic [6:0] char_addr,
  output logic       busy,
  output logic       err_busy_wr
);

  localparam int MAX_CYCLES = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept, busy_wr;

  logic       e_s1, e_s2, e_prev;
  logic       rs_s1, rs_s2, rw_s1, rw_s2;
  logic [7:0] db_s1, db_s2;
  logic       rs_l, rw_l;
  logic [7:0] db_l;
  logic [6:0] ac;
  logic       id;

  logic strobe, wr_stb, is_clear;

  // Bus fields are held from the last cycle E was seen high, so they are valid at the falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_s1 <= 1'b0; e_s2 <= 1'b0; e_prev <= 1'b0;
      rs_s1 <= 1'b0; rs_s2 <= 1'b0;
      rw_s1 <= 1'b0; rw_s2 <= 1'b0;
      db_s1 <= 8'h00; db_s2 <= 8'h00;
      rs_l <= 1'b0; rw_l <= 1'b0; db_l <= 8'h00;
    end else begin
      e_s1  <= LCD_E;  e_s2  <= e_s1;  e_prev <= e_s2;
      rs_s1 <= LCD_RS; rs_s2 <= rs_s1;
      rw_s1 <= LCD_RW; rw_s2 <= rw_s1;
      db_s1 <= LCD_DB; db_s2 <= db_s1;
      if (e_s2) begin
        rs_l <= rs_s2;
        rw_l <= rw_s2;
        db_l <= db_s2;
      end
    end
  end

  assign strobe   = e_prev & ~e_s2;
  assign wr_stb   = strobe & ~rw_l;
  assign is_clear = ~rs_l & ((db_l == 8'h01) | (db_l == 8'h02) | (db_l == 8'h03));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A strobe landing on the final busy cycle still sees BUSY and is rejected.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    busy_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_stb) begin
          accept  = 1'b1;
          state_d = BUSY;
          cnt_d   = is_clear ? CW'(CLEAR_CYCLES - 1) : CW'(BUSY_CYCLES - 1);
        end
      end
      BUSY: begin
        busy_wr = wr_stb;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_valid   <= 1'b0;
      cmd_code    <= 8'h00;
      char_valid  <= 1'b0;
      char_data   <= 8'h00;
      char_addr   <= 7'h00;
      err_busy_wr <= 1'b0;
      ac          <= 7'h00;
      id          <= 1'b1;
    end else begin
      cmd_valid   <= accept & ~rs_l;
      char_valid  <= accept & rs_l;
      err_busy_wr <= busy_wr;
      if (accept) begin
        if (rs_l) begin
          char_data <= db_l;
          char_addr <= ac;
          ac        <= id ? ac + 7'd1 : ac - 7'd1;
        end else begin
          cmd_code <= db_l;
          if (db_l == 8'h01) begin
            ac <= 7'h00;
            id <= 1'b1;
          end else if ((db_l == 8'h02) || (db_l == 8'h03)) begin
            ac <= 7'h00;
          end else if (db_l[7:2] == 6'b000001) begin
            id <= db_l[1];
          end else if (db_l[7]) begin
            ac <= db_l[6:0];
          end
        end
      end
    end
  end

`ifdef LCD_BUS_RESPONDER_READ_EN
  assign LCD_DB_oe = e_s2 & rw_s2;
  assign LCD_DB_rd = rs_s2 ? 8'h00 : {busy, ac};
`else
  assign LCD_DB_oe = 1'b0;
  assign LCD_DB_rd = 8'h00;
`endif

endmodule

// File: doc/lcd_bus_responder.md
LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 2000: busy time for ordinary commands and data writes (40 us at 50 MHz).
REQ-002 SHALL have parameter CLEAR_CYCLES, default 82000: busy time for clear and home commands (1.64 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port LCD_DB  input  8  data bus driven by the controller.
REQ-006 SHALL have ports LCD_RS, LCD_RW, LCD_E  input  1 each  register select, read/write and enable strobes.
REQ-007 SHALL have ports LCD_DB_rd  output  8  and LCD_DB_oe  output  1  read-back data and its drive enable.
REQ-008 SHALL have ports cmd_valid  output  1  and cmd_code  output  8  one-cycle pulse with the accepted instruction byte.
REQ-009 SHALL have ports char_valid  output  1,  char_data  output  8  and char_addr  output  7  one-cycle pulse with the accepted character and its DDRAM address.
REQ-010 SHALL have ports busy  output  1  busy flag, and err_busy_wr  output  1  one-cycle pulse when a write arrives while busy.

Function
REQ-011 SHALL pass LCD_E, LCD_RS, LCD_RW and LCD_DB through a 2-flop synchronizer each.
REQ-012 SHALL keep a third register holding the previous synchronized E.
REQ-013 SHALL detect a strobe when the synchronized E is 0 and the previous E is 1 (falling edge).
REQ-014 SHALL use RS, RW and DB as sampled on the last cycle E was high; this is the value applied at the strobe.
REQ-015 SHALL run a state machine with states IDLE and BUSY, plus a busy counter.
REQ-016 SHALL set busy = 1 exactly when the state is BUSY.
REQ-017 SHALL, on a write strobe (RW = 0) in IDLE, pulse the decoded outputs one cycle after the strobe, then enter BUSY.
REQ-018 SHALL leave BUSY after BUSY_CYCLES cycles, or after CLEAR_CYCLES cycles for 0x01, 0x02 and 0x03.
REQ-019 SHALL, on a write strobe in BUSY, ignore the write, pulse err_busy_wr, and leave state and counter unchanged.
REQ-020 SHALL, for an RS = 0 write, pulse cmd_valid with cmd_code = DB.
REQ-021 SHALL, for RS = 0 write 0x01, set AC = 0 and ID = 1.
REQ-022 SHALL, for RS = 0 writes 0x02 and 0x03, set AC = 0.
REQ-023 SHALL, for RS = 0 writes 0x04 to 0x07, set ID = DB[1].
REQ-024 SHALL, for RS = 0 writes 0x80 to 0xFF, set AC = DB[6:0].
REQ-025 SHALL leave AC and ID unchanged for all other RS = 0 codes (display control, shift, function set, CGRAM address) while still reporting them on cmd_valid.
REQ-026 SHALL, for an RS = 1 write, pulse char_valid with char_data = DB and char_addr = AC (before update).
REQ-027 SHALL, after an RS = 1 write, set AC = AC+1 if ID = 1, else AC-1, modulo 128 (0x7F+1 gives 0x00; 0x00-1 gives 0x7F).
REQ-028 SHALL NOT assert cmd_valid and char_valid in the same cycle.
REQ-029 SHALL ignore a strobe that coincides with the BUSY-to-IDLE transition cycle.
REQ-030 SHALL hold LCD_DB_oe = 0 whenever RW = 0 or E is low.

Reset
REQ-031 SHALL, while rst = 0, immediately force: state IDLE, busy 0, counter 0, AC 0x00, ID 1, synchronizers 0, all pulses 0, cmd_code 0, char_data 0, char_addr 0, LCD_DB_rd 0, LCD_DB_oe 0.
REQ-032 SHALL, on reset asserted mid-BUSY, abort the busy period; the first strobe after release is accepted.

Configuration
REQ-033 SHALL compile read-back support only when macro LCD_BUS_RESPONDER_READ_EN is defined.
REQ-034 SHALL, with the macro, drive LCD_DB_oe = 1 while the synchronized E = 1 and RW = 1.
REQ-035 SHALL, with the macro, drive LCD_DB_rd = {busy, AC} when RS = 0 and 0x00 when RS = 1.
REQ-036 SHALL NOT let a read strobe change AC, state or the pulse outputs, and SHALL NOT raise err_busy_wr for a read.
REQ-037 SHALL, without the macro, tie LCD_DB_oe and LCD_DB_rd to 0 and ignore strobes with RW = 1.

Verification
REQ-038 SHALL cover: reset release, then RS=0 DB=0x38 write -> cmd_valid with 0x38, busy high for exactly 2000 cycles.
REQ-039 SHALL cover: after idle, DB=0x01 -> AC=0, busy for 82000 cycles; a DB=0x41 RS=1 write at cycle 1000 -> err_busy_wr pulse, no char_valid.
REQ-040 SHALL cover: DB=0xFF command then RS=1 writes 0x33, 0x23 -> char_addr 0x7F then 0x00.
REQ-041 SHALL cover: DB=0x04 (ID=0), DB=0x80, RS=1 write 0x56 -> char_addr 0x00, then the next char_addr is 0x7F.
REQ-042 SHALL cover: rst low at cycle 500 of a busy period -> busy 0 within one cycle; the next write is accepted.
REQ-043 SHALL cover, with LCD_BUS_RESPONDER_READ_EN: AC=0x05 while busy, RS=0 RW=1 E high -> LCD_DB_oe=1, LCD_DB_rd=0x85; after busy ends -> 0x05.
